// File: rtl/ad9739_pkg.sv
// Shared definitions for the AD9739 receive-side alignment path and its loopback checker.
package ad9739_pkg;

  localparam int SLOTS = 8;

  localparam logic [13:0] DEF_PATTERN_EVEN = 14'h2AAA;
  localparam logic [13:0] DEF_PATTERN_ODD  = 14'h1555;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    SLIP,
    WAIT,
    LOCKED,
    FAIL
  } align_state_t;

endpackage

// File: rtl/ad9739_rx_align_if.sv
// Deserializer-to-capture bus: two DDR banks in, reassembled AXIS samples out.
interface ad9739_rx_align_if
  import ad9739_pkg::*;
#(
  parameter int DATA_WIDTH    = 14,
  parameter int PARALLEL_NUMS = 16
);

  logic                          din_valid;
  logic [SLOTS*DATA_WIDTH-1:0]   din_a;
  logic [SLOTS*DATA_WIDTH-1:0]   din_b;
  logic [16*PARALLEL_NUMS-1:0]   m_tdata;
  logic                          m_tvalid;

  modport master (input din_valid, din_a, din_b, output m_tdata, m_tvalid);
  modport slave  (output din_valid, din_a, din_b, input m_tdata, m_tvalid);

endinterface

// File: rtl/ad9739_rx_pattern_cmp.sv
// Combinational training-pattern compare over all slots of both banks.
module ad9739_rx_pattern_cmp
  import ad9739_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 14,
  parameter logic [DATA_WIDTH-1:0] PATTERN_EVEN = DEF_PATTERN_EVEN,
  parameter logic [DATA_WIDTH-1:0] PATTERN_ODD  = DEF_PATTERN_ODD
) (
  input  logic                        valid,
  input  logic [SLOTS*DATA_WIDTH-1:0] din_a,
  input  logic [SLOTS*DATA_WIDTH-1:0] din_b,
  output logic                        match
);

  always_comb begin
    match = valid;
    for (int k = 0; k < SLOTS; k++) begin
      if (din_a[k*DATA_WIDTH +: DATA_WIDTH] != PATTERN_EVEN ||
          din_b[k*DATA_WIDTH +: DATA_WIDTH] != PATTERN_ODD) begin
        match = 1'b0;
      end
    end
  end

endmodule

// File: rtl/ad9739_rx_align.sv
// Word-aligns the two deserializer banks to the training pattern via bitslip,
// then streams the reassembled 16-sample words on the AXIS side of the bus.
module ad9739_rx_align
  import ad9739_pkg::*;
#(
  parameter int                    DATA_WIDTH    = 14,
  parameter int                    PARALLEL_NUMS = 16,
  parameter logic [DATA_WIDTH-1:0] PATTERN_EVEN  = DEF_PATTERN_EVEN,
  parameter logic [DATA_WIDTH-1:0] PATTERN_ODD   = DEF_PATTERN_ODD,
  parameter int                    SLIP_WAIT     = 4,
  parameter int                    LOCK_CNT      = 8
) (
  input  logic                     adc_clk,
  input  logic                     adc_rst,
  input  logic                     align_start,
  ad9739_rx_align_if.master        bus,
  output logic                     bitslip,
  output logic                     aligned,
  output logic                     align_fail,
  output logic [2:0]               slip_count,
  output logic [15:0]              err_cnt
);

  localparam int OUT_W = 16 * PARALLEL_NUMS;

  align_state_t     state;
  logic [7:0]       match_cnt;
  logic [3:0]       wait_cnt;
  logic             match;
  logic [OUT_W-1:0] next_tdata;

  ad9739_rx_pattern_cmp #(
    .DATA_WIDTH   (DATA_WIDTH),
    .PATTERN_EVEN (PATTERN_EVEN),
    .PATTERN_ODD  (PATTERN_ODD)
  ) u_cmp (
    .valid (bus.din_valid),
    .din_a (bus.din_a),
    .din_b (bus.din_b),
    .match (match)
  );

  // The slip pulse is raised on entry to SLIP so a simultaneous restart can suppress it.
  always_ff @(posedge adc_clk) begin
    if (adc_rst) begin
      state      <= IDLE;
      bitslip    <= 1'b0;
      aligned    <= 1'b0;
      align_fail <= 1'b0;
      slip_count <= 3'd0;
      err_cnt    <= 16'd0;
      match_cnt  <= 8'd0;
      wait_cnt   <= 4'd0;
    end else begin
      bitslip <= 1'b0;
      if (align_start) begin
        state      <= CHECK;
        aligned    <= 1'b0;
        align_fail <= 1'b0;
        slip_count <= 3'd0;
        match_cnt  <= 8'd0;
        err_cnt    <= 16'd0;
      end else begin
        case (state)
          IDLE: ;
          CHECK: begin
            if (bus.din_valid) begin
              if (match) begin
                match_cnt <= match_cnt + 8'd1;
                if (match_cnt == 8'(LOCK_CNT - 1)) begin
                  state   <= LOCKED;
                  aligned <= 1'b1;
                end
              end else if (slip_count == 3'd7) begin
                state      <= FAIL;
                align_fail <= 1'b1;
              end else begin
                state      <= SLIP;
                bitslip    <= 1'b1;
                slip_count <= slip_count + 3'd1;
                match_cnt  <= 8'd0;
              end
            end
          end
          SLIP: begin
            wait_cnt <= 4'd0;
            state    <= WAIT;
          end
          WAIT: begin
            if (wait_cnt == 4'(SLIP_WAIT - 1)) state <= CHECK;
            else wait_cnt <= wait_cnt + 4'd1;
          end
          LOCKED: begin
            if (bus.din_valid && !match && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
          end
          FAIL: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Bank a holds even samples, bank b odd; raw bits are left-justified in each 16-bit lane.
  for (genvar k = 0; k < SLOTS; k++) begin : g_slot
    assign next_tdata[(2*k)*16 +: 16]   = 16'(bus.din_a[k*DATA_WIDTH +: DATA_WIDTH]) << (16 - DATA_WIDTH);
    assign next_tdata[(2*k+1)*16 +: 16] = 16'(bus.din_b[k*DATA_WIDTH +: DATA_WIDTH]) << (16 - DATA_WIDTH);
  end

  always_ff @(posedge adc_clk) begin
    if (adc_rst) begin
      bus.m_tdata  <= '0;
      bus.m_tvalid <= 1'b0;
    end else begin
      bus.m_tdata  <= next_tdata;
      bus.m_tvalid <= bus.din_valid & aligned;
    end
  end

endmodule

// File: tb/tb_ad9739_rx_align.sv
// Self-checking bench for ad9739_rx_align: deserializer slip model, scoreboard and vector table.
module tb_ad9739_rx_align;
  import ad9739_pkg::*;

  localparam int          DW        = 14;
  localparam int          SLIP_WAIT = 4;
  localparam int          LOCK_CNT  = 8;
  localparam logic [13:0] PE        = 14'h2AAA;
  localparam logic [13:0] PO        = 14'h1555;

  typedef logic [8*DW-1:0] bank_t;
  typedef logic [255:0]    out_t;
  typedef struct { logic v; out_t d; } sb_t;
  typedef struct { logic valid; bank_t a; bank_t b; logic exp_v; out_t exp_d; } vec_t;

  logic        adc_clk = 1'b0;
  logic        adc_rst;
  logic        align_start;
  logic        bitslip;
  logic        aligned;
  logic        align_fail;
  logic [2:0]  slip_count;
  logic [15:0] err_cnt;

  ad9739_rx_align_if #(.DATA_WIDTH(DW), .PARALLEL_NUMS(16)) bus();

  ad9739_rx_align #(
    .DATA_WIDTH    (DW),
    .PARALLEL_NUMS (16),
    .PATTERN_EVEN  (PE),
    .PATTERN_ODD   (PO),
    .SLIP_WAIT     (SLIP_WAIT),
    .LOCK_CNT      (LOCK_CNT)
  ) dut (
    .adc_clk     (adc_clk),
    .adc_rst     (adc_rst),
    .align_start (align_start),
    .bus         (bus),
    .bitslip     (bitslip),
    .aligned     (aligned),
    .align_fail  (align_fail),
    .slip_count  (slip_count),
    .err_cnt     (err_cnt)
  );

  always #5 adc_clk = ~adc_clk;

  int  check_cnt;
  int  pass_cnt;
  sb_t sb_q[$];
  int  offset;
  int  slips_seen;
  int  idle;
  bit  zero_mode;
  bit  prev_slip;
  bit  saw_tvalid;

  function automatic bank_t fill(input logic [DW-1:0] w);
    bank_t r;
    for (int k = 0; k < 8; k++) r[k*DW +: DW] = w;
    return r;
  endfunction

  function automatic out_t expand(input bank_t a, input bank_t b);
    out_t r;
    for (int k = 0; k < 8; k++) begin
      r[(2*k)*16 +: 16]   = {a[k*DW +: DW], 2'b00};
      r[(2*k+1)*16 +: 16] = {b[k*DW +: DW], 2'b00};
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input out_t act, input out_t exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // One clock; also tracks bitslip pulses for the deserializer model.
  task automatic tick();
    @(posedge adc_clk);
    #1;
    if (prev_slip) checkOutput("bitslip_width", out_t'(bitslip), out_t'(0));
    if (bitslip && !prev_slip) begin
      if (idle >= 0) checkOutput("slip_spacing", out_t'(idle), out_t'(SLIP_WAIT + 1));
      slips_seen++;
      idle = 0;
    end else if (!bitslip && idle >= 0) begin
      idle++;
    end
    prev_slip = bitslip;
    if (bus.m_tvalid) saw_tvalid = 1'b1;
  endtask

  task automatic applyStimulus(input logic v, input bank_t a, input bank_t b,
                               input bit use_sb, input logic ev, input out_t ed);
    sb_t e;
    bus.din_valid = v;
    bus.din_a     = a;
    bus.din_b     = b;
    if (use_sb) sb_q.push_back('{ev, ed});
    tick();
    if (use_sb) begin
      e = sb_q.pop_front();
      checkOutput("m_tvalid", out_t'(bus.m_tvalid), out_t'(e.v));
      checkOutput("m_tdata", bus.m_tdata, e.d);
    end
  endtask

  // Deserializer model: data stays misaligned until `offset` slips have been received.
  task automatic drive_model(input logic v);
    bank_t a;
    bank_t b;
    int    rem;
    rem = offset - slips_seen;
    if (zero_mode) begin
      a = '0;
      b = '0;
    end else if (rem > 0) begin
      a = fill(PE ^ 14'(rem));
      b = fill(PO ^ 14'(rem));
    end else begin
      a = fill(PE);
      b = fill(PO);
    end
    applyStimulus(v, a, b, 1'b0, 1'b0, '0);
  endtask

  task automatic restart(input int off, input bit zmode);
    offset      = off;
    zero_mode   = zmode;
    align_start = 1'b1;
    bus.din_valid = 1'b0;
    tick();
    align_start = 1'b0;
    slips_seen  = 0;
    idle        = -1;
  endtask

  task automatic check_all_zero(input string tag);
    checkOutput({tag, "_bitslip"}, out_t'(bitslip), out_t'(0));
    checkOutput({tag, "_aligned"}, out_t'(aligned), out_t'(0));
    checkOutput({tag, "_align_fail"}, out_t'(align_fail), out_t'(0));
    checkOutput({tag, "_slip_count"}, out_t'(slip_count), out_t'(0));
    checkOutput({tag, "_err_cnt"}, out_t'(err_cnt), out_t'(0));
    checkOutput({tag, "_m_tvalid"}, out_t'(bus.m_tvalid), out_t'(0));
    checkOutput({tag, "_m_tdata"}, bus.m_tdata, out_t'(0));
  endtask

  initial begin
    vec_t  vecs[8];
    bank_t ra;
    bank_t rb;
    bank_t ca;
    out_t  exp_ramp;
    out_t  pat_out;
    int    n;

    check_cnt = 0;
    pass_cnt  = 0;
    offset = 0; slips_seen = 0; idle = -1;
    zero_mode = 1'b0; prev_slip = 1'b0; saw_tvalid = 1'b0;
    adc_rst = 1'b1; align_start = 1'b0;
    bus.din_valid = 1'b0; bus.din_a = '0; bus.din_b = '0;

    for (int k = 0; k < 8; k++) begin
      ra[k*DW +: DW] = 14'(4*k);
      rb[k*DW +: DW] = 14'(4*k + 1);
      exp_ramp[(2*k)*16 +: 16]   = 16'((4*k) << 2);
      exp_ramp[(2*k+1)*16 +: 16] = 16'((4*k + 1) << 2);
    end
    pat_out = {8{16'h5554, 16'hAAA8}};
    ca = fill(PE ^ 14'h0100);

    repeat (3) tick();
    check_all_zero("reset");
    adc_rst = 1'b0;
    tick();

    $display("[TB] zero-offset alignment");
    restart(0, 1'b0);
    for (int i = 0; i < LOCK_CNT - 1; i++) begin
      if (i == 4) drive_model(1'b0);
      drive_model(1'b1);
    end
    checkOutput("lock_not_early", out_t'(aligned), out_t'(0));
    drive_model(1'b1);
    checkOutput("lock_at_cnt", out_t'(aligned), out_t'(1));
    checkOutput("lock0_slip_count", out_t'(slip_count), out_t'(0));
    checkOutput("lock0_pulses", out_t'(slips_seen), out_t'(0));
    applyStimulus(1'b1, fill(PE), fill(PO), 1'b1, 1'b1, pat_out);

    $display("[TB] offset 3 alignment");
    restart(3, 1'b0);
    n = 0;
    while (!aligned && n < 300) begin drive_model(1'b1); n++; end
    checkOutput("off3_aligned", out_t'(aligned), out_t'(1));
    checkOutput("off3_slip_count", out_t'(slip_count), out_t'(3));
    checkOutput("off3_pulses", out_t'(slips_seen), out_t'(3));

    $display("[TB] restart coincident with slip decision");
    restart(1, 1'b0);
    align_start = 1'b1;
    drive_model(1'b1);
    align_start = 1'b0;
    checkOutput("restart_wins_bitslip", out_t'(bitslip), out_t'(0));
    checkOutput("restart_wins_count", out_t'(slip_count), out_t'(0));
    slips_seen = 0;
    idle = -1;
    n = 0;
    while (!aligned && n < 300) begin drive_model(1'b1); n++; end
    checkOutput("off1_aligned", out_t'(aligned), out_t'(1));
    checkOutput("off1_pulses", out_t'(slips_seen), out_t'(1));

    $display("[TB] never matching data");
    restart(0, 1'b1);
    saw_tvalid = 1'b0;
    n = 0;
    while (!align_fail && n < 300) begin drive_model(1'b1); n++; end
    checkOutput("fail_flag", out_t'(align_fail), out_t'(1));
    checkOutput("fail_aligned", out_t'(aligned), out_t'(0));
    checkOutput("fail_slip_count", out_t'(slip_count), out_t'(7));
    checkOutput("fail_pulses", out_t'(slips_seen), out_t'(7));
    checkOutput("fail_no_tvalid", out_t'(saw_tvalid), out_t'(0));
    applyStimulus(1'b1, ra, rb, 1'b1, 1'b0, exp_ramp);

    $display("[TB] error counting while locked");
    restart(0, 1'b0);
    n = 0;
    while (!aligned && n < 300) begin drive_model(1'b1); n++; end
    checkOutput("err_lock", out_t'(aligned), out_t'(1));
    checkOutput("err_initial", out_t'(err_cnt), out_t'(0));
    repeat (5) applyStimulus(1'b1, ca, fill(PO), 1'b1, 1'b1, expand(ca, fill(PO)));
    checkOutput("err_five", out_t'(err_cnt), out_t'(5));
    checkOutput("err_five_aligned", out_t'(aligned), out_t'(1));
    repeat (70000) applyStimulus(1'b1, ca, fill(PO), 1'b0, 1'b0, '0);
    checkOutput("err_saturate", out_t'(err_cnt), out_t'(16'hFFFF));
    checkOutput("err_sat_aligned", out_t'(aligned), out_t'(1));

    $display("[TB] reassembly vector table");
    vecs[0] = '{1'b1, ra, rb, 1'b1, exp_ramp};
    vecs[1] = '{1'b0, ra, rb, 1'b0, exp_ramp};
    vecs[2] = '{1'b1, fill(14'h3FFF), fill(14'h3FFF), 1'b1, {16{16'hFFFC}}};
    vecs[3] = '{1'b0, fill(PE), fill(PO), 1'b0, pat_out};
    for (int i = 4; i < 8; i++) begin
      vecs[i].valid = 1'(i);
      vecs[i].a     = bank_t'({$urandom(), $urandom(), $urandom(), $urandom()});
      vecs[i].b     = bank_t'({$urandom(), $urandom(), $urandom(), $urandom()});
      vecs[i].exp_v = 1'(i);
      vecs[i].exp_d = expand(vecs[i].a, vecs[i].b);
    end
    for (int i = 0; i < 8; i++)
      applyStimulus(vecs[i].valid, vecs[i].a, vecs[i].b, 1'b1, vecs[i].exp_v, vecs[i].exp_d);
    checkOutput("table_err_held", out_t'(err_cnt), out_t'(16'hFFFF));

    $display("[TB] reset during wait");
    restart(5, 1'b0);
    n = 0;
    while (slips_seen < 2 && n < 100) begin drive_model(1'b1); n++; end
    checkOutput("mid_two_slips", out_t'(slips_seen), out_t'(2));
    drive_model(1'b1);
    adc_rst = 1'b1;
    drive_model(1'b1);
    check_all_zero("midrst");
    adc_rst = 1'b0;
    tick();
    restart(0, 1'b0);
    checkOutput("post_rst_slip_count", out_t'(slip_count), out_t'(0));
    n = 0;
    while (!aligned && n < 300) begin drive_model(1'b1); n++; end
    checkOutput("post_rst_aligned", out_t'(aligned), out_t'(1));
    checkOutput("post_rst_pulses", out_t'(slips_seen), out_t'(0));

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
